cond_logic: RTL and testbench

Condition unit on the consumer side of the ALU flag outputs. Holds the architectural NZCV flag register, updates it from the ALU's `{negative, zero, carry, overflow}` outputs, and evaluates the 4-bit ARM condition field against the stored flags. Sits between the instruction decoder and the datapath write enables, gating register, memory and PC writes of non-executing instructions. Sized for the multicycle controller: state advances only on the execute strobe.

---
 rtl/arm_cond_pkg.sv | 29 ++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_logic.sv | 73 +++++++
 tb/tb_cond_logic.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arm_cond_pkg.sv
// Shared definitions for ARM condition-code handling: condition encodings
// and bit positions of the NZCV flags.
package arm_cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational evaluator of a 4-bit ARM condition field against NZCV.
module cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_hit
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field; the 1111 encoding is reserved and never executes.
    always_comb begin
        cond_hit = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_hit = z;
            COND_NE: cond_hit = ~z;
            COND_CS: cond_hit = c;
            COND_CC: cond_hit = ~c;
            COND_MI: cond_hit = n;
            COND_PL: cond_hit = ~n;
            COND_VS: cond_hit = v;
            COND_VC: cond_hit = ~v;
            COND_HI: cond_hit = c & ~z;
            COND_LS: cond_hit = ~c | z;
            COND_GE: cond_hit = (n == v);
            COND_LT: cond_hit = (n != v);
            COND_GT: cond_hit = ~z & (n == v);
            COND_LE: cond_hit = z | (n != v);
            COND_AL: cond_hit = 1'b1;
            COND_NV: cond_hit = 1'b0;
            default: cond_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Condition unit: architectural NZCV register, registered condition result
// of the last executed instruction, and gating of datapath write enables.
module cond_logic
    import arm_cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       ex_en,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags,
    output logic       cond_ex
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_q;
    logic       cond_ex_d;
    logic       cond_hit;

    // Condition is evaluated against the stored (pre-update) flags.
    cond_check u_cond_check (
        .cond     (cond),
        .flags    (flags_q),
        .cond_hit (cond_hit)
    );

    // Next-state: on an execute strobe, latch the condition result and update
    // each flag group independently when the instruction executes.
    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if (ex_en) begin
            cond_ex_d = cond_hit;
            if (cond_hit && flag_w[1]) begin
                flags_d[FLAG_N] = alu_flags[FLAG_N];
                flags_d[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (cond_hit && flag_w[0]) begin
                flags_d[FLAG_C] = alu_flags[FLAG_C];
                flags_d[FLAG_V] = alu_flags[FLAG_V];
            end
        end
    end

    // State registers with synchronous reset dominating the execute strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign flags     = flags_q;
    assign cond_ex   = cond_ex_q;
    assign pc_src    = pcs & cond_ex_q;
    assign reg_write = reg_w & cond_ex_q & ~no_write;
    assign mem_write = mem_w & cond_ex_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios plus randomized
// traffic compared against a behavioural model of the condition unit.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       ex_en;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;
    logic       cond_ex;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [3:0] m_flags;
    logic       m_cond_ex;

    cond_logic #(.RESET_FLAGS(4'b0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .ex_en     (ex_en),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .flags     (flags),
        .cond_ex   (cond_ex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ARM-style evaluation: condition pairs share a base test, odd encodings invert.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic drive(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                         input logic ex, input logic p, input logic rw, input logic mw,
                         input logic nw);
        cond = c; alu_flags = af; flag_w = fw; ex_en = ex;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle(input string tag);
        logic hit;
        @(posedge clk);
        if (reset) begin
            m_flags   = 4'b0000;
            m_cond_ex = 1'b0;
        end else if (ex_en) begin
            hit       = ref_cond(cond, m_flags);
            m_cond_ex = hit;
            if (hit && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
            if (hit && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
        end
        #1;
        check({tag, ".flags"},     flags,            m_flags);
        check({tag, ".cond_ex"},   {3'b0, cond_ex},   {3'b0, m_cond_ex});
        check({tag, ".pc_src"},    {3'b0, pc_src},    {3'b0, pcs & m_cond_ex});
        check({tag, ".reg_write"}, {3'b0, reg_write}, {3'b0, reg_w & m_cond_ex & ~no_write});
        check({tag, ".mem_write"}, {3'b0, mem_write}, {3'b0, mem_w & m_cond_ex});
    endtask

    initial begin
        logic [3:0] hold_flags;
        logic       hold_cex;
        m_flags   = 4'b0000;
        m_cond_ex = 1'b0;

        // Reset with a competing execute strobe
        reset = 1'b1;
        drive(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("reset0");
        cycle("reset1");
        check("reset_flags_const", flags, 4'b0000);
        reset = 1'b0;

        // Split update: N,Z only then C,V only
        drive(4'b1110, 4'b1111, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("split_nz");
        check("split_nz_const", flags, 4'b1100);
        drive(4'b1110, 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("split_cv");
        check("split_cv_const", flags, 4'b1111);

        // Signed compare with N=1,V=0
        reset = 1'b1; drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("rst2");
        reset = 1'b0;
        drive(4'b1110, 4'b1000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("set_n");
        drive(4'b1010, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("ge");
        check("ge_reg_write_const", {3'b0, reg_write}, 4'b0000);
        drive(4'b1011, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("lt");
        check("lt_reg_write_const", {3'b0, reg_write}, 4'b0001);

        // Suppressed update when condition fails
        reset = 1'b1; cycle("rst3"); reset = 1'b0;
        drive(4'b0000, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("eq_fail");
        check("eq_fail_flags_const", flags, 4'b0000);

        // Compare-class op: flags update, register write suppressed
        drive(4'b1110, 4'b0110, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("cmp");
        check("cmp_flags_const", flags, 4'b0110);
        check("cmp_reg_write_const", {3'b0, reg_write}, 4'b0000);
        drive(4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("nv");
        check("nv_pc_src_const", {3'b0, pc_src}, 4'b0000);

        // Hold: no execute strobe for 5 cycles under random inputs
        drive(4'b1110, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("pre_hold");
        hold_flags = m_flags;
        hold_cex   = m_cond_ex;
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom), 4'($urandom), 2'($urandom), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            cycle("hold");
            check("hold_flags", flags, hold_flags);
            check("hold_cond_ex", {3'b0, cond_ex}, {3'b0, hold_cex});
        end

        // Randomized traffic, mostly back-to-back strobes, occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(4'($urandom), 4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            cycle("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
